barrett_const_gen: RTL and testbench

- Sequential constant generator sitting directly upstream of the modular multiplier.
- From a modulus P it computes the Barrett constant T = floor(2^(2W)/P), a W+1-bit value.
- It outputs the latched P together with T so the multiplier always receives a consistent P/T pair.
- Implemented as a radix-2 restoring divider, one quotient bit per cycle, with a start/busy/done handshake.

---
 rtl/barrett_const_gen.sv | 157 +++++++++++++++
 tb/tb_barrett_const_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/barrett_const_gen.sv
// barrett_const_gen: computes the Barrett constant T = floor(2^(2W)/P) for a
// modulus P with a radix-2 restoring divider, one quotient bit per cycle.
// It presents the latched P next to T, so the downstream modular multiplier
// always receives a matching pair.
// Optional feature macro: BARRETT_REM_EN adds rem_out = 2^(2W) mod P.
module barrett_const_gen #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] p_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] p_out,
   output logic [WIDTH:0]   t_out
`ifdef BARRETT_REM_EN
   ,
   output logic [WIDTH-1:0] rem_out
`endif
);

   localparam int CNT_W = $clog2(2*WIDTH+1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH:0]   quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH:0]   t_q, t_d;
   logic             err_q, err_d;
`ifdef BARRETT_REM_EN
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
`endif

   logic             p_valid;
   logic             div_bit;
   logic [WIDTH+1:0] r_shift;
   logic             r_ge;
   logic [WIDTH:0]   r_sub;
   logic [WIDTH:0]   r_next;
   logic [WIDTH:0]   q_next;

   // One restoring-division step: the dividend is a single 1 at bit 2W, so
   // only the first iteration shifts in a 1.  The partial remainder stays
   // below P, so the trial subtraction fits in W+1 bits once R' >= P.
   always_comb begin
      p_valid = p_in[WIDTH-1] && (p_in[WIDTH-2:0] != '0);
      div_bit = (cnt_q == '0);
      r_shift = {rem_q, div_bit};
      r_ge    = (r_shift >= {2'b00, p_q});
      r_sub   = r_shift[WIDTH:0] - {1'b0, p_q};
      r_next  = r_ge ? r_sub : r_shift[WIDTH:0];
      q_next  = {quo_q[WIDTH-1:0], r_ge};
   end

   // Next-state and register-update logic; results move only at accept or
   // completion.  On completion, the bit shifted out of Q must be zero for a
   // legal modulus, so it is reused as a sanity flag on err.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      t_d     = t_q;
      err_d   = err_q;
`ifdef BARRETT_REM_EN
      rem_out_d = rem_out_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               p_d = p_in;
               if (p_valid) begin
                  state_d = DIV;
                  rem_d   = '0;
                  quo_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  t_d     = '0;
`ifdef BARRETT_REM_EN
                  rem_out_d = '0;
`endif
               end
            end
         end
         DIV: begin
            rem_d = r_next;
            quo_d = q_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               t_d     = q_next;
               err_d   = quo_q[WIDTH];
`ifdef BARRETT_REM_EN
               rem_out_d = r_next[WIDTH-1:0];
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         t_q     <= '0;
         err_q   <= 1'b0;
`ifdef BARRETT_REM_EN
         rem_out_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         t_q     <= t_d;
         err_q   <= err_d;
`ifdef BARRETT_REM_EN
         rem_out_q <= rem_out_d;
`endif
      end
   end

   assign busy  = (state_q == DIV);
   assign done  = (state_q == DONE);
   assign err   = err_q;
   assign p_out = p_q;
   assign t_out = t_q;
`ifdef BARRETT_REM_EN
   assign rem_out = rem_out_q;
`endif

endmodule

// File: tb/tb_barrett_const_gen.sv
// tb_barrett_const_gen: randomized and directed checks of barrett_const_gen
// against a plain-arithmetic reference (128-bit divide of 2^64 by P).
// Honors BARRETT_REM_EN to also check rem_out.
module tb_barrett_const_gen;

   localparam int W = 32;
   localparam int LAT = 2*W + 1;
   localparam int MAX_WAIT = 200;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  p_in;
   logic          busy;
   logic          done;
   logic          err;
   logic [W-1:0]  p_out;
   logic [W:0]    t_out;
`ifdef BARRETT_REM_EN
   logic [W-1:0]  rem_out;
`endif

   int vectors = 0;
   int miscompares = 0;

   barrett_const_gen #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .p_in  (p_in),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .p_out (p_out),
      .t_out (t_out)
`ifdef BARRETT_REM_EN
      ,
      .rem_out (rem_out)
`endif
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if it does not match
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit isValid(input logic [W-1:0] p);
      return (p > 32'h8000_0000);
   endfunction

   function automatic logic [W:0] refT(input logic [W-1:0] p);
      logic [127:0] dvd;
      logic [127:0] q;
      dvd = 128'd1 << (2*W);
      q = dvd / {96'd0, p};
      return q[W:0];
   endfunction

   function automatic logic [W-1:0] refRem(input logic [W-1:0] p);
      logic [127:0] dvd;
      logic [127:0] r;
      dvd = 128'd1 << (2*W);
      r = dvd % {96'd0, p};
      return r[W-1:0];
   endfunction

   // Waits for done, sampling on falling edges; tracks busy length, overlap
   // with done, and whether t_out moved before completion.
   task automatic waitDone(input logic [W:0] prevT, output int busyCnt,
                           output bit timedOut, output bit overlap, output bit moved);
      int cycles;
      busyCnt = 0; timedOut = 1'b0; overlap = 1'b0; moved = 1'b0; cycles = 0;
      while (!done && cycles < MAX_WAIT) begin
         if (busy) begin
            busyCnt++;
            if (t_out !== prevT) moved = 1'b1;
         end
         @(negedge clk);
         cycles++;
      end
      if (!done) timedOut = 1'b1;
      if (busy && done) overlap = 1'b1;
   endtask

   // Checks the result sampled in the done cycle
   task automatic checkResult(input string tag, input logic [W-1:0] p);
      bit v;
      v = isValid(p);
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_err"}, 64'(err), 64'(!v));
      checkOutput({tag, "_t"}, 64'(t_out), v ? 64'(refT(p)) : 64'd0);
      checkOutput({tag, "_p"}, 64'(p_out), 64'(p));
`ifdef BARRETT_REM_EN
      checkOutput({tag, "_rem"}, 64'(rem_out), v ? 64'(refRem(p)) : 64'd0);
`endif
   endtask

   // Issues one start pulse and checks the full transaction; returns at the
   // falling edge of the done cycle.
   task automatic applyStimulus(input string tag, input logic [W-1:0] p);
      logic [W:0] prevT;
      int busyCnt;
      bit timedOut, overlap, moved;
      @(negedge clk);
      checkOutput({tag, "_done_low_before"}, 64'(done), 64'd0);
      prevT = t_out;
      p_in = p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      p_in = $urandom;
      waitDone(prevT, busyCnt, timedOut, overlap, moved);
      checkOutput({tag, "_timeout"}, 64'(timedOut), 64'd0);
      checkOutput({tag, "_busy_len"}, 64'(busyCnt), isValid(p) ? 64'(LAT) : 64'd0);
      checkOutput({tag, "_overlap"}, 64'(overlap), 64'd0);
      checkOutput({tag, "_t_held"}, 64'(moved), 64'd0);
      checkResult(tag, p);
   endtask

   initial begin
      logic [W-1:0] rp;
      logic [W:0]   prevT;
      int busyCnt;
      bit timedOut, overlap, moved, sawDone;

      rst = 1'b1; start = 1'b0; p_in = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_p", 64'(p_out), 64'd0);
      checkOutput("rst_t", 64'(t_out), 64'd0);
`ifdef BARRETT_REM_EN
      checkOutput("rst_rem", 64'(rem_out), 64'd0);
`endif
      rst = 1'b0;

      // Directed values from the plan; the last two also cover back-to-back
      applyStimulus("nominal", 32'hF5CD_384B);
      checkOutput("nominal_const", 64'(t_out), 64'h1_0A9F_1A16);
      applyStimulus("max", 32'hFFFF_FFFF);
      checkOutput("max_const", 64'(t_out), 64'h1_0000_0001);
      applyStimulus("minvalid", 32'h8000_0001);
      checkOutput("minvalid_const", 64'(t_out), 64'h1_FFFF_FFFC);
      applyStimulus("inv_small", 32'h1234_5678);
      applyStimulus("inv_half", 32'h8000_0000);
      applyStimulus("b2b_a", 32'hC000_0003);
      applyStimulus("b2b_b", 32'hA5A5_A5A5);

      // Start during DIV with a different modulus must be ignored
      @(negedge clk);
      prevT = t_out;
      p_in = 32'hF5CD_384B; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      p_in = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(prevT, busyCnt, timedOut, overlap, moved);
      busyCnt += 10;
      checkOutput("prot_timeout", 64'(timedOut), 64'd0);
      checkOutput("prot_busy_len", 64'(busyCnt), 64'(LAT));
      checkResult("prot", 32'hF5CD_384B);
      @(negedge clk);
      checkOutput("prot_single_done", 64'(done), 64'd0);
      checkOutput("prot_idle", 64'(busy), 64'd0);

      // Asynchronous reset mid-division
      @(negedge clk);
      p_in = 32'hF5CD_384B; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      checkOutput("abort_busy_pre", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_err", 64'(err), 64'd0);
      checkOutput("abort_t", 64'(t_out), 64'd0);
      checkOutput("abort_p", 64'(p_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      sawDone = 1'b0;
      repeat (LAT + 5) begin
         @(negedge clk);
         if (done || busy) sawDone = 1'b1;
      end
      checkOutput("abort_quiet", 64'(sawDone), 64'd0);
      applyStimulus("after_abort", 32'hFFFF_FFFF);

      // Randomized moduli, mostly valid, some invalid
      for (int i = 0; i < 24; i++) begin
         rp = $urandom;
         if ((i % 4) != 3) rp[W-1] = 1'b1;
         if (i == 5) rp = 32'h8000_0000 | ($urandom_range(1, 15));
         applyStimulus($sformatf("rand%0d", i), rp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
